// File: rtl/int_ack_ctrl.sv
// int_ack_ctrl: round-robin interrupt arbiter with host acknowledge, one-hot source clear and clear timeout.
module int_ack_ctrl #(
    parameter int NUM_SRC = 8,
    parameter int TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [2:0]  Addr,
    output logic [15:0] DataRd,
    input  logic [15:0] DataWr,
    input  logic        En,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [7:0]  IntStatus,
    output logic [7:0]  IntReset,
    output logic        Irq
);
    typedef enum logic [1:0] {IDLE, PEND, CLEAR, WAIT} stateT;
    stateT state, nextState;
    logic [7:0] Enable, req;
    logic [2:0] Vector, LastVec, nextVec, idx;
    logic [3:0] WaitCnt;
    logic Valid, ErrAck, ErrTmo, found;
    logic wrEn, ackWr, ackMatch, withdraw, srcHigh, waitLast, unusedBits;
    assign req = IntStatus & Enable;
    assign wrEn = En & Wr;
    assign ackWr = wrEn && Addr == 3'd2;
    assign ackMatch = ackWr && DataWr[2:0] == Vector;
    assign srcHigh = IntStatus[Vector];
    assign withdraw = !srcHigh || !Enable[Vector];
    assign waitLast = WaitCnt == 4'(TIMEOUT - 1);
    assign Irq = Valid;
    assign IntReset = (state == CLEAR) ? 8'b1 << Vector : 8'h00;
    assign unusedBits = ^{Rd, DataWr[15:8]};
    assign DataRd = !En ? 16'h0000 :
                    Addr == 3'd0 ? {8'h00, Enable} :
                    Addr == 3'd1 ? {8'h00, Valid, ErrAck, ErrTmo, 2'b00, Vector} :
                    Addr == 3'd3 ? {8'h00, IntStatus} : 16'h0000;
    // search starts just above the last serviced source so every source gets a turn
    always_comb begin
        nextVec = Vector;
        found = 1'b0;
        idx = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = LastVec + 3'(i) + 3'd1;
            if (!found && req[idx]) begin
                nextVec = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        nextState = state;
        case (state)
            IDLE:  nextState = (req != 8'h00) ? PEND : IDLE;
            PEND:  nextState = withdraw ? IDLE : ackMatch ? CLEAR : PEND;
            CLEAR: nextState = WAIT;
            WAIT:  nextState = (!srcHigh || waitLast) ? IDLE : WAIT;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else state <= nextState;
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Enable <= 8'h00;
            Vector <= 3'd0;
            LastVec <= 3'd7;
            WaitCnt <= 4'd0;
            Valid <= 1'b0;
            ErrAck <= 1'b0;
            ErrTmo <= 1'b0;
        end else begin
            if (state == IDLE && req != 8'h00) begin
                Vector <= nextVec;
                Valid <= 1'b1;
            end
            if (state == PEND && (withdraw || ackMatch)) Valid <= 1'b0;
            if (state == PEND && !withdraw && ackMatch) LastVec <= Vector;
            if (state == CLEAR) WaitCnt <= 4'd0;
            if (state == WAIT && srcHigh) WaitCnt <= WaitCnt + 4'd1;
            if (wrEn && Addr == 3'd0) Enable <= DataWr[7:0];
            // a matching ack that loses to withdrawal is not an error
            ErrAck <= (ackWr && !(state == PEND && ackMatch)) ? 1'b1 :
                      (wrEn && Addr == 3'd1 && DataWr[6]) ? 1'b0 : ErrAck;
            ErrTmo <= (state == WAIT && srcHigh && waitLast) ? 1'b1 :
                      (wrEn && Addr == 3'd1 && DataWr[5]) ? 1'b0 : ErrTmo;
        end
    end
endmodule

// File: tb/tb_int_ack_ctrl.sv
// tb_int_ack_ctrl: directed self-checking bench for int_ack_ctrl.
module tb_int_ack_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic [2:0] Addr = 3'd0;
    logic [15:0] DataRd;
    logic [15:0] DataWr = 16'h0000;
    logic En = 1'b0;
    logic Rd = 1'b0;
    logic Wr = 1'b0;
    logic [7:0] IntStatus = 8'h00;
    logic [7:0] IntReset;
    logic Irq;
    int checks = 0;
    int failures = 0;

    int_ack_ctrl #(.NUM_SRC(8), .TIMEOUT(15)) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataRd(DataRd), .DataWr(DataWr),
        .En(En), .Rd(Rd), .Wr(Wr), .IntStatus(IntStatus), .IntReset(IntReset), .Irq(Irq)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [15:0] d);
        Addr = a;
        DataWr = d;
        Wr = 1'b1;
        step();
        Wr = 1'b0;
    endtask

    task automatic chkRd(input string tag, input logic [2:0] a, input logic [15:0] exp);
        Addr = a;
        #1;
        chk(tag, DataRd, exp);
    endtask

    task automatic serviceRR(input logic [2:0] v);
        chkRd("rr_vec", 3'd1, 16'h0080 | 16'(v));
        write(3'd2, 16'(v));
        chk("rr_intreset", 16'(IntReset), 16'(8'b1 << v));
        IntStatus = 8'h03 & ~(8'b1 << v);
        step();
        step();
        IntStatus = 8'h03;
        step();
    endtask

    initial begin
        step();
        step();
        chk("rst_irq", 16'(Irq), 16'h0000);
        chk("rst_intreset", 16'(IntReset), 16'h0000);
        #2 Reset = 1'b1;
        En = 1'b1;
        chkRd("rst_addr1", 3'd1, 16'h0000);
        chkRd("rst_addr0", 3'd0, 16'h0000);

        write(3'd0, 16'h00FF);
        chkRd("enable_rd", 3'd0, 16'h00FF);
        IntStatus = 8'h24;
        chkRd("status_rd", 3'd3, 16'h0024);
        chkRd("addr2_rd", 3'd2, 16'h0000);
        En = 1'b0;
        chkRd("en0_rd", 3'd3, 16'h0000);
        En = 1'b1;
        chk("irq_latency", 16'(Irq), 16'h0000);
        step();
        chk("irq_set", 16'(Irq), 16'h0001);
        chkRd("vec2", 3'd1, 16'h0082);
        write(3'd2, 16'h0002);
        chk("clr_pulse", 16'(IntReset), 16'h0004);
        chk("clr_irq", 16'(Irq), 16'h0000);
        step();
        chk("pulse_once", 16'(IntReset), 16'h0000);
        IntStatus = 8'h20;
        step();
        chk("idle_irq", 16'(Irq), 16'h0000);
        step();
        chkRd("vec5", 3'd1, 16'h0085);
        write(3'd2, 16'h0005);
        chk("clr5_pulse", 16'(IntReset), 16'h0020);
        IntStatus = 8'h00;
        step();
        step();

        IntStatus = 8'h03;
        step();
        serviceRR(3'd0);
        serviceRR(3'd1);
        serviceRR(3'd0);
        serviceRR(3'd1);

        chkRd("pend_vec0", 3'd1, 16'h0080);
        write(3'd0, 16'h0000);
        chk("dis_reset0", 16'(IntReset), 16'h0000);
        step();
        chk("dis_irq", 16'(Irq), 16'h0000);
        chk("dis_reset1", 16'(IntReset), 16'h0000);
        step();
        chk("dis_reset2", 16'(IntReset), 16'h0000);
        chkRd("dis_addr1", 3'd1, 16'h0000);

        IntStatus = 8'h00;
        write(3'd0, 16'h00FF);
        IntStatus = 8'h10;
        step();
        chkRd("vec4", 3'd1, 16'h0084);
        write(3'd2, 16'h0003);
        chk("badack_reset", 16'(IntReset), 16'h0000);
        chk("badack_irq", 16'(Irq), 16'h0001);
        chkRd("badack_err", 3'd1, 16'h00C4);
        write(3'd1, 16'h0040);
        chkRd("errack_clr", 3'd1, 16'h0084);

        write(3'd2, 16'h0004);
        chk("tmo_pulse", 16'(IntReset), 16'h0010);
        step();
        for (int i = 0; i < 14; i++) step();
        chkRd("tmo_wait", 3'd1, 16'h0004);
        chk("tmo_noreset", 16'(IntReset), 16'h0000);
        step();
        chkRd("tmo_err", 3'd1, 16'h0024);
        write(3'd1, 16'h0020);
        chkRd("errtmo_clr", 3'd1, 16'h0084);

        write(3'd2, 16'h0004);
        chk("rstclr_pulse", 16'(IntReset), 16'h0010);
        Reset = 1'b0;
        #1;
        chk("rstclr_reset", 16'(IntReset), 16'h0000);
        chk("rstclr_irq", 16'(Irq), 16'h0000);
        step();
        #2 Reset = 1'b1;
        chkRd("rstclr_addr1", 3'd1, 16'h0000);
        chkRd("rstclr_addr0", 3'd0, 16'h0000);

        write(3'd0, 16'h00FF);
        step();
        chkRd("rw_vec4", 3'd1, 16'h0084);
        write(3'd2, 16'h0004);
        step();
        chk("rw_wait_reset", 16'(IntReset), 16'h0000);
        Reset = 1'b0;
        #1;
        chk("rw_irq", 16'(Irq), 16'h0000);
        chk("rw_reset", 16'(IntReset), 16'h0000);
        step();
        #2 Reset = 1'b1;
        chkRd("rw_addr1", 3'd1, 16'h0000);

        write(3'd2, 16'h0001);
        chkRd("idle_ack_err", 3'd1, 16'h0040);
        chk("idle_ack_reset", 16'(IntReset), 16'h0000);
        write(3'd1, 16'h0060);
        chkRd("w1c_both", 3'd1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_ack_ctrl.md
INT_ACK_CTRL -- requirements
Module: int_ack_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8: number of interrupt sources; fixed at 8 in this revision.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles for a source to clear after IntReset.
REQ-003 SHALL have ports:
- Clk  input  1  sole clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Addr  input  3  register select.
- DataRd  output  16  read data.
- DataWr  input  16  write data.
- En  input  1  block select.
- Rd  input  1  read strobe.
- Wr  input  1  write strobe, sampled when En=1.
- IntStatus  input  8  per-source pending flags from GPIO interrupt block.
- IntReset  output  8  one-hot clear pulse back to GPIO interrupt block.
- Irq  output  1  interrupt request to host.

Function
REQ-004 SHALL have registers: Enable[7:0], Vector[2:0], LastVec[2:0], Valid, ErrAck, ErrTmo, WaitCnt[3:0], and a 4-state FSM: IDLE, PEND, CLEAR, WAIT.
REQ-005 SHALL form Req = IntStatus & Enable every cycle, combinationally.
REQ-006 IDLE: if Req!=0, SHALL latch Vector = first set bit of Req searching upward from LastVec+1 mod 8, set Valid=1 and Irq=1, and go to PEND at the next edge.
REQ-007 SHALL round-robin: LastVec is updated to Vector on entry to CLEAR only.
REQ-008 PEND: a write (En&Wr) to Addr 2 with DataWr[2:0]==Vector SHALL move to CLEAR and drop Irq and Valid at the same edge.
REQ-009 PEND: a write to Addr 2 with DataWr[2:0]!=Vector SHALL be ignored except that ErrAck is set.
REQ-010 PEND: if IntStatus[Vector]==0 or Enable[Vector]==0, the request is withdrawn: SHALL return to IDLE, clear Irq and Valid, and issue no IntReset.
REQ-011 Withdrawal SHALL take priority over a simultaneous matching acknowledge; in that case ErrAck is not set.
REQ-012 CLEAR: SHALL drive IntReset = 1<<Vector for exactly one cycle, clear WaitCnt, and go to WAIT; IntReset SHALL be 0 in all other states.
REQ-013 WAIT: SHALL go to IDLE when IntStatus[Vector]==0; otherwise increment WaitCnt, and when WaitCnt reaches TIMEOUT SHALL set ErrTmo and go to IDLE.
REQ-014 Writes to Addr 2 outside PEND SHALL be ignored and SHALL set ErrAck.
REQ-015 Writes: Addr 0 SHALL load Enable = DataWr[7:0]; Addr 1 SHALL be write-1-to-clear, DataWr[6] clearing ErrAck and DataWr[5] clearing ErrTmo; Addr 3-7 SHALL be ignored.
REQ-016 Reads SHALL be combinational and independent of Rd:
- Addr0 = {8'h00, Enable}.
- Addr1 = {8'h00, Valid, ErrAck, ErrTmo, 2'b00, Vector}.
- Addr2 = 16'h0000.
- Addr3 = {8'h00, IntStatus}.
- Other addresses, or En=0, = 16'h0000.
REQ-017 Latency SHALL be: IntStatus bit rising at edge N gives Irq=1 after edge N+1; an acknowledge sampled at edge M gives IntReset high in cycle M+1 only.
REQ-018 Sticky-bit set and W1C clear in the same cycle: set SHALL win.

Reset
REQ-019 Reset low SHALL immediately force:
- FSM = IDLE.
- Enable, Vector, WaitCnt, Valid, ErrAck, ErrTmo, Irq, IntReset = 0.
- LastVec = 7, so the first search starts at bit 0.
REQ-020 Reset asserted mid-operation (any state) SHALL abandon the cycle with no IntReset pulse; after release the block resumes from IDLE.

Verification
REQ-021 Enable=8'hFF, IntStatus=8'h24 -> Irq=1, Addr1 reads 16'h0082; ack 3'd2 -> IntReset=8'h04 for one cycle; IntStatus[2] drops -> IDLE; next request serves vector 5 (Addr1=16'h0085).
REQ-022 Round-robin: IntStatus=8'h03 held, each serviced source re-asserted immediately -> service order 0,1,0,1.
REQ-023 In PEND with Vector=4, write Addr2 DataWr=3 -> no IntReset, Irq stays 1, Addr1 bit6=1; then write Addr1 DataWr=16'h0040 -> bit6=0.
REQ-024 In PEND, Enable written to 8'h00 -> Irq=0 next cycle, IntReset never pulses, FSM IDLE.
REQ-025 After ack, IntStatus held high -> IDLE after 15 WAIT cycles with ErrTmo=1; then Addr1 bit5=1.
REQ-026 Reset pulled low in CLEAR and in WAIT -> IntReset=0 and Irq=0 immediately; Addr1=16'h0000 after release.
